// File: rtl/rx_frame_pkg.sv
// Shared types and defaults for the 8b/10b receive frame buffer.
package rx_frame_pkg;

    localparam logic [7:0] SOF_DEFAULT     = 8'hFB;
    localparam int         MAX_LEN_DEFAULT = 16;
    localparam int         DEPTH_DEFAULT   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } rxState_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifoEntry_t;

endpackage

// File: rtl/rx_frame_buffer_if.sv
// Byte stream from the deserializer plus the valid/ready payload stream to the consumer.
interface rx_frame_buffer_if;

    logic [7:0] data_i;
    logic       eob_i;
    logic       code_err_i;
    logic       disp_err_i;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic       m_last_o;

    modport master (
        output data_i,
        output eob_i,
        output code_err_i,
        output disp_err_i,
        output m_ready_i,
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o
    );

    modport slave (
        input  data_i,
        input  eob_i,
        input  code_err_i,
        input  disp_err_i,
        input  m_ready_i,
        output m_data_o,
        output m_valid_o,
        output m_last_o
    );

endinterface

// File: rtl/frame_fifo.sv
// Payload FIFO with a speculative write pointer: bytes become readable only once
// the parser commits the frame, and a rollback discards everything since the last commit.
module frame_fifo
    import rx_frame_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wrEn_i,
    input  fifoEntry_t               wrEntry_i,
    input  logic                     commit_i,
    input  logic                     rollback_i,
    input  logic                     rdReady_i,
    output fifoEntry_t               rdEntry_o,
    output logic                     rdValid_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fifoEntry_t    mem_q [DEPTH];
    logic [PW-1:0] rdPtr_q;
    logic [PW-1:0] rdPtr_d;
    logic [PW-1:0] specPtr_q;
    logic [PW-1:0] specPtr_d;
    logic [PW-1:0] commitPtr_q;
    logic [PW-1:0] commitPtr_d;
    logic          pop;

    assign rdValid_o = (commitPtr_q != rdPtr_q);
    assign pop       = rdValid_o && rdReady_i;
    assign rdEntry_o = mem_q[rdPtr_q[AW-1:0]];
    assign free_o    = PW'(DEPTH) - (specPtr_q - rdPtr_q);

    always_comb begin
        rdPtr_d     = rdPtr_q;
        specPtr_d   = specPtr_q;
        commitPtr_d = commitPtr_q;
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (rollback_i) begin
            specPtr_d = commitPtr_q;
        end else if (wrEn_i) begin
            specPtr_d = specPtr_q + PW'(1);
        end
        if (commit_i) begin
            commitPtr_d = specPtr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdPtr_q     <= '0;
            specPtr_q   <= '0;
            commitPtr_q <= '0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            specPtr_q   <= specPtr_d;
            commitPtr_q <= commitPtr_d;
        end
    end

    // Storage needs no reset: nothing is readable until the pointers say so.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[specPtr_q[AW-1:0]] <= wrEntry_i;
        end
    end

endmodule

// File: rtl/rx_frame_buffer.sv
// Frame parser for SOF/LEN/payload/CHK frames; payload is buffered in frame_fifo
// and released to the consumer only after the checksum byte matches.
module rx_frame_buffer
    import rx_frame_pkg::*;
#(
    parameter int         DEPTH   = DEPTH_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT,
    parameter logic [7:0] SOF     = SOF_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rx_frame_buffer_if.slave   bus,
    output logic               frame_ok_o,
    output logic               frame_drop_o,
    output logic [15:0]        drop_cnt_o
);

    localparam int CW = $clog2(MAX_LEN + 1);

    rxState_e              state_q;
    rxState_e              state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [7:0]            chk_q;
    logic [7:0]            chk_d;
    logic                  okPulse_q;
    logic                  okPulse_d;
    logic                  dropPulse_q;
    logic                  dropPulse_d;
    logic [15:0]           dropCnt_q;
    logic [15:0]           dropCnt_d;

    logic                  wrEn;
    fifoEntry_t            wrEntry;
    logic                  commit;
    logic                  rollback;
    fifoEntry_t            rdEntry;
    logic                  rdValid;
    logic [$clog2(DEPTH):0] freeCnt;
    logic                  byteErr;
    logic                  lenBad;

    frame_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wrEn_i     (wrEn),
        .wrEntry_i  (wrEntry),
        .commit_i   (commit),
        .rollback_i (rollback),
        .rdReady_i  (bus.m_ready_i),
        .rdEntry_o  (rdEntry),
        .rdValid_o  (rdValid),
        .free_o     (freeCnt)
    );

    assign byteErr = bus.code_err_i || bus.disp_err_i;
    // Space is checked up front so a frame can never overwrite unread data.
    assign lenBad  = (bus.data_i == 8'd0) || (int'(bus.data_i) > MAX_LEN)
                     || (int'(bus.data_i) > int'(freeCnt));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        wrEn        = 1'b0;
        wrEntry     = '0;
        commit      = 1'b0;
        okPulse_d   = 1'b0;
        dropPulse_d = 1'b0;
        if (bus.eob_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.data_i == SOF && !byteErr) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (byteErr || lenBad) begin
                        dropPulse_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d   = CW'(bus.data_i);
                        chk_d   = bus.data_i;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (byteErr) begin
                        dropPulse_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        wrEn         = 1'b1;
                        wrEntry.data = bus.data_i;
                        wrEntry.last = (cnt_q == CW'(1));
                        chk_d        = chk_q ^ bus.data_i;
                        cnt_d        = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (!byteErr && bus.data_i == chk_q) begin
                        commit    = 1'b1;
                        okPulse_d = 1'b1;
                    end else begin
                        dropPulse_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        rollback  = dropPulse_d;
        dropCnt_d = dropCnt_q;
        if (dropPulse_d && dropCnt_q != 16'hFFFF) begin
            dropCnt_d = dropCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            chk_q       <= '0;
            okPulse_q   <= 1'b0;
            dropPulse_q <= 1'b0;
            dropCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            okPulse_q   <= okPulse_d;
            dropPulse_q <= dropPulse_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    assign bus.m_data_o  = rdEntry.data;
    assign bus.m_last_o  = rdEntry.last;
    assign bus.m_valid_o = rdValid;
    assign frame_ok_o    = okPulse_q;
    assign frame_drop_o  = dropPulse_q;
    assign drop_cnt_o    = dropCnt_q;

endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 Parameter DEPTH, 32, payload FIFO entries (power of two, >= MAX_LEN).
REQ-002 Parameter MAX_LEN, 16, largest legal payload length in bytes.
REQ-003 Parameter SOF, 8'hFB, start-of-frame byte value.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 data_i  in  8  decoded byte from the 8b/10b deserializer.
REQ-007 eob_i  in  1  byte strobe; data_i, code_err_i and disp_err_i are valid when 1.
REQ-008 code_err_i  in  1  invalid 10b code on this byte.
REQ-009 disp_err_i  in  1  running-disparity error on this byte.
REQ-010 m_data_o  out  8  payload byte to the consumer.
REQ-011 m_valid_o  out  1  m_data_o valid.
REQ-012 m_ready_i  in  1  consumer accepts; transfer when m_valid_o and m_ready_i are both 1.
REQ-013 m_last_o  out  1  last payload byte of the frame, qualified by m_valid_o.
REQ-014 frame_ok_o  out  1  one-cycle pulse: frame committed.
REQ-015 frame_drop_o  out  1  one-cycle pulse: frame discarded.
REQ-016 drop_cnt_o  out  16  count of discarded frames, saturating at 16'hFFFF.

Function
REQ-017 Frame format: SOF, LEN (1..MAX_LEN), LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-018 The block shall advance only on cycles with eob_i=1; with eob_i=0 the parser state is held.
REQ-019 States: IDLE, LEN, PAYLOAD, CHK.
REQ-020 IDLE: byte==SOF with no error flags -> LEN; any other byte, including errored bytes, is ignored.
REQ-021 LEN: a value of 0, a value above MAX_LEN, or a value above the free entries -> drop and go to IDLE; otherwise load the byte counter and checksum with LEN and go to PAYLOAD.
REQ-022 PAYLOAD: each byte is written at the speculative write pointer with a last flag, XORed into the checksum, and the counter decrements; after the LEN-th byte -> CHK.
REQ-023 An SOF value inside PAYLOAD or CHK is treated as ordinary data.
REQ-024 CHK: byte==checksum -> committed pointer := speculative pointer, pulse frame_ok_o; otherwise speculative pointer := committed pointer and drop; both cases -> IDLE.
REQ-025 code_err_i or disp_err_i on any byte in LEN, PAYLOAD or CHK -> drop and go to IDLE.
REQ-026 A drop shall pulse frame_drop_o for one cycle, increment drop_cnt_o unless it is saturated, and restore the speculative pointer.
REQ-027 m_valid_o = (committed pointer != read pointer); bytes of an uncommitted frame shall never be visible.
REQ-028 Latency: the first byte of a frame appears on m_valid_o one cycle after the edge that samples the good CHK byte, coincident with the frame_ok_o pulse.
REQ-029 Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; free entries = DEPTH - (speculative pointer - read pointer).
REQ-030 A read in the same cycle as a commit or drop shall be handled correctly; a read frees space that is usable in the next cycle.
REQ-031 m_data_o and m_last_o shall be stable while m_valid_o=1 and m_ready_i=0.

Reset
REQ-032 On rst_ni=0 at a clock edge: state=IDLE; all pointers=0; checksum and counter=0; m_valid_o=0; frame_ok_o=0; frame_drop_o=0; drop_cnt_o=0.
REQ-033 A reset mid-frame or with data pending shall discard all content, and no pulse shall be issued for the aborted frame.

Structure
REQ-034 Package rx_frame_pkg shall hold the state enum, the SOF and MAX_LEN defaults, and the 9-bit FIFO entry typedef (data plus last flag).
REQ-035 Sub-module frame_fifo shall contain the storage, read/speculative/committed pointers, commit/rollback inputs and the free-count output; rx_frame_buffer contains the parser.

Verification
REQ-036 Stream FB 03 11 22 33 03 with m_ready_i=1 -> frame_ok_o pulse; output 11, 22, 33 with m_last_o on 33.
REQ-037 Stream FB 03 11 22 33 04 -> frame_drop_o pulse, drop_cnt_o=1, m_valid_o stays 0.
REQ-038 Stream FB 02 AA, then BB with code_err_i=1 -> drop and return to IDLE; a following good frame FB 01 55 54 is delivered as 55 with last.
REQ-039 Send LEN=0 and LEN=17 frames -> two drops; with m_ready_i=0, send two 16-byte good frames -> the second is dropped for lack of space (DEPTH=32 holds 32, so pre-fill with 1-byte frames to force the overflow).
REQ-040 Assert rst_ni=0 for one cycle mid-PAYLOAD -> all outputs at reset values; a later good frame is delivered intact.
